imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
- Upstream programming stage for the single-cycle RISC-V core.
- Accepts a byte stream of instructions over a valid/ready handshake and assembles the bytes little-endian into 32-bit words.
- Writes each assembled word into instruction memory at an auto-incrementing word address.
- Sequences the core: holds it halted while loading, then issues a one-cycle core reset and asserts start to run the new program.

Parameters:
IMEM_DEPTH, 32, number of 32-bit words in instruction memory.
ADDR_W, 5, width of the word address; must satisfy 2**ADDR_W >= IMEM_DEPTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
load_en  input  1  level; high requests or continues a load session.
run_req  input  1  level; high requests program execution.
rx_data  input  8  incoming instruction byte.
rx_valid  input  1  rx_data is valid this cycle.
rx_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  one-cycle instruction-memory write strobe.
imem_addr  output  ADDR_W  word address for the write.
imem_wdata  output  32  assembled instruction word.
cpu_start  output  1  enables core execution; high only in RUN.
cpu_reset  output  1  one-cycle reset pulse to the core on entry to RUN.
word_count  output  ADDR_W+1  words written in the last or current session.
load_done  output  1  one-cycle pulse when a session closes.
overflow  output  1  sticky flag: a word arrived after memory was full.
partial_err  output  1  sticky flag: session ended with 1-3 unassembled bytes.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0; word_count, imem_addr, the internal byte counter and the assembly register clear.
  - Reset has priority over every other input, including in the middle of a word or a session.
- States: IDLE, LOAD, FINISH, RUN. All outputs are registered except rx_ready, which is a decode of state == LOAD.
- IDLE:
  - load_en=1 → LOAD. Entering LOAD clears word_count, the word pointer, the byte counter, overflow and partial_err.
  - Else run_req=1 → RUN. load_en has priority when both inputs are high.
- LOAD:
  - rx_ready=1. A byte is accepted when rx_valid && rx_ready.
  - The byte with byte counter k (0..3) lands in bits [8k+7:8k]; the counter then increments modulo 4.
  - On acceptance of the byte with k=3:
    - If pointer < IMEM_DEPTH: on the next cycle imem_we=1, imem_addr=pointer, imem_wdata=assembled word (zero-based first address). Pointer and word_count increment with the write.
    - If pointer == IMEM_DEPTH: no write, overflow=1, and later bytes are still accepted and discarded.
  - Write latency is exactly 1 cycle after the 4th byte handshake. Back-to-back words at one byte per cycle give imem_we every 4th cycle.
  - imem_addr and imem_wdata hold their last values when imem_we=0.
  - load_en=0 → FINISH. A byte handshaken in the same cycle that load_en falls is still accepted, and its pending write still occurs.
- FINISH: one cycle.
  - rx_ready=0 and load_done=1.
  - If byte counter != 0, partial_err=1 and the partial word is discarded (no write). The byte counter then clears.
  - Next state is IDLE.
- RUN:
  - The entry cycle has cpu_reset=1 and cpu_start=0.
  - From the following cycle cpu_start=1 until exit.
  - load_en=1 → LOAD, with cpu_start dropping in the same cycle the state changes.
  - Else run_req=0 → IDLE.
  - rx_ready=0 and imem_we=0 throughout RUN.
- word_count saturates at IDLE_DEPTH=IMEM_DEPTH and never wraps. overflow and partial_err persist until the next LOAD entry or reset.

Test Plan:
- Single word load:
  - Stimulus: reset, load_en=1, then bytes 13,0E,AE,00 on consecutive cycles, then load_en=0.
  - Required response: imem_we one cycle after the 4th byte, imem_addr=0, imem_wdata=32'h00AE0E13; word_count=1; load_done pulse in FINISH; partial_err=0.
- Full memory and overflow:
  - Stimulus: stream 33 words (132 bytes) with rx_valid held high.
  - Required response: 32 writes at addresses 0..31, with imem_we every 4 cycles; no 33rd write; overflow=1; word_count=32.
- Partial word:
  - Stimulus: 6 bytes, then load_en=0.
  - Required response: one write only; partial_err=1 at FINISH; word_count=1; byte counter clear on the next LOAD.
- Run sequencing:
  - Stimulus: after a load, run_req=1.
  - Required response: cpu_reset=1 for exactly one cycle with cpu_start=0; then cpu_start=1 held. After run_req=0, cpu_start=0 one cycle later and state is IDLE.
- Reload during run:
  - Stimulus: in RUN, assert load_en.
  - Required response: cpu_start drops immediately; flags and word_count clear; new bytes are written starting at address 0.
- Reset mid-word and handshake gaps:
  - Stimulus: 2 bytes, then reset, then a fresh session. In a separate run, toggle rx_valid with idle gaps.
  - Required response: after reset all outputs are 0 and the first write of the fresh session is at address 0 with correct data. With gaps, only handshaken bytes assemble and the data is unchanged.

Source files
------------

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: packs a byte stream into 32-bit words, writes instruction memory, then resets and starts the core.
module imem_stream_loader #(
  parameter int IMEM_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              run_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              overflow,
  output logic              partial_err
);
  typedef enum logic [1:0] {IDLE, LOAD, FINISH, RUN} state_t;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(IMEM_DEPTH);
  state_t state_q, state_d;
  logic [1:0] bc_q, bc_d;
  logic [23:0] asm_q, asm_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic we_q, we_d, start_q, start_d, crst_q, crst_d, done_q, done_d, ov_q, ov_d, pe_q, pe_d;
  logic accept, last, fits, enter_load;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bc_q    <= '0;
      asm_q   <= '0;
      wc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      crst_q  <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      asm_q   <= asm_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      start_q <= start_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      pe_q    <= pe_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load_en ? LOAD : run_req ? RUN : IDLE;
      LOAD:    state_d = load_en ? LOAD : FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = load_en ? LOAD : run_req ? RUN : IDLE;
    endcase
  end
  always_comb begin
    accept     = (state_q == LOAD) && rx_valid;
    last       = accept && (bc_q == 2'd3);
    fits       = wc_q < DEPTH;
    enter_load = (state_d == LOAD) && (state_q != LOAD);
    bc_d       = enter_load ? 2'd0 : accept ? bc_q + 2'd1 : (state_q == FINISH) ? 2'd0 : bc_q;
    asm_d      = {(accept && bc_q == 2'd2) ? rx_data : asm_q[23:16],
                  (accept && bc_q == 2'd1) ? rx_data : asm_q[15:8],
                  (accept && bc_q == 2'd0) ? rx_data : asm_q[7:0]};
    we_d       = last && fits;
    addr_d     = we_d ? wc_q[ADDR_W-1:0] : addr_q;
    wdata_d    = we_d ? {rx_data, asm_q} : wdata_q;
    wc_d       = enter_load ? '0 : wc_q + {{ADDR_W{1'b0}}, we_d};
    ov_d       = enter_load ? 1'b0 : ov_q | (last && !fits);
    // a session closing with a nonzero byte count leaves a torn word behind
    pe_d       = enter_load ? 1'b0 : pe_q | ((state_q == LOAD) && (state_d == FINISH) && (bc_d != 2'd0));
    done_d     = state_d == FINISH;
    crst_d     = (state_d == RUN) && (state_q != RUN);
    start_d    = (state_d == RUN) && (state_q == RUN);
  end
  assign rx_ready    = state_q == LOAD;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_start   = start_q;
  assign cpu_reset   = crst_q;
  assign word_count  = wc_q;
  assign load_done   = done_q;
  assign overflow    = ov_q;
  assign partial_err = pe_q;
endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: directed scenario tasks with inline checks against hand-computed values.
module tb_imem_stream_loader;
  logic clk = 1'b0;
  logic reset, load_en, run_req, rx_valid;
  logic [7:0] rx_data;
  logic rx_ready, imem_we, cpu_start, cpu_reset, load_done, overflow, partial_err;
  logic [4:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [5:0] word_count;
  int errs = 0;
  int checks = 0;

  imem_stream_loader #(.IMEM_DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .run_req(run_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_start(cpu_start), .cpu_reset(cpu_reset), .word_count(word_count),
    .load_done(load_done), .overflow(overflow), .partial_err(partial_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_en = 1'b0; run_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    step(); step();
    checks++; if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_start, cpu_reset, word_count, load_done, overflow, partial_err} !== 50'd0) begin errs++; $display("FAIL reset_outputs: got we=%b addr=%0d wdata=%h wc=%0d start=%b", imem_we, imem_addr, imem_wdata, word_count, cpu_start); end
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    logic [7:0] b [4];
    b = '{8'h13, 8'h0E, 8'hAE, 8'h00};
    load_en = 1'b1; step();
    checks++; if (rx_ready !== 1'b1) begin errs++; $display("FAIL single_ready: got %b exp 1", rx_ready); end
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = b[i]; step();
      if (i < 3) begin
        checks++; if (imem_we !== 1'b0) begin errs++; $display("FAIL single_early_we byte %0d: got %b exp 0", i, imem_we); end
      end
    end
    checks++; if (imem_we !== 1'b1) begin errs++; $display("FAIL single_we: got %b exp 1", imem_we); end
    checks++; if (imem_addr !== 5'd0) begin errs++; $display("FAIL single_addr: got %0d exp 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h00AE0E13) begin errs++; $display("FAIL single_wdata: got %h exp 00ae0e13", imem_wdata); end
    checks++; if (word_count !== 6'd1) begin errs++; $display("FAIL single_wc: got %0d exp 1", word_count); end
    rx_valid = 1'b0; load_en = 1'b0; step();
    checks++; if (load_done !== 1'b1) begin errs++; $display("FAIL single_done: got %b exp 1", load_done); end
    checks++; if (rx_ready !== 1'b0) begin errs++; $display("FAIL single_finish_ready: got %b exp 0", rx_ready); end
    checks++; if (imem_we !== 1'b0) begin errs++; $display("FAIL single_we_drop: got %b exp 0", imem_we); end
    checks++; if (imem_wdata !== 32'h00AE0E13) begin errs++; $display("FAIL single_wdata_hold: got %h exp 00ae0e13", imem_wdata); end
    checks++; if (partial_err !== 1'b0) begin errs++; $display("FAIL single_perr: got %b exp 0", partial_err); end
    step();
    checks++; if (load_done !== 1'b0) begin errs++; $display("FAIL single_done_pulse: got %b exp 0", load_done); end
  endtask

  task automatic test_full_memory();
    int nw;
    logic [31:0] exp_word;
    nw = 0;
    load_en = 1'b1; step();
    checks++; if (word_count !== 6'd0) begin errs++; $display("FAIL full_wc_clear: got %0d exp 0", word_count); end
    for (int i = 0; i < 132; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i) ^ 8'h5C; step();
      if (imem_we === 1'b1) nw++;
      if (i % 4 == 3) begin
        exp_word = {8'(i) ^ 8'h5C, 8'(i - 1) ^ 8'h5C, 8'(i - 2) ^ 8'h5C, 8'(i - 3) ^ 8'h5C};
        checks++; if (imem_we !== (i / 4 < 32)) begin errs++; $display("FAIL full_we word %0d: got %b exp %b", i / 4, imem_we, (i / 4 < 32)); end
        if (i / 4 < 32) begin
          checks++; if (imem_addr !== 5'(i / 4)) begin errs++; $display("FAIL full_addr word %0d: got %0d exp %0d", i / 4, imem_addr, i / 4); end
          checks++; if (imem_wdata !== exp_word) begin errs++; $display("FAIL full_wdata word %0d: got %h exp %h", i / 4, imem_wdata, exp_word); end
        end
      end else begin
        checks++; if (imem_we !== 1'b0) begin errs++; $display("FAIL full_gap_we byte %0d: got %b exp 0", i, imem_we); end
      end
      if (i == 127) begin
        checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL full_early_ovf: got %b exp 0", overflow); end
      end
    end
    rx_valid = 1'b0;
    checks++; if (nw !== 32) begin errs++; $display("FAIL full_write_count: got %0d exp 32", nw); end
    checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL full_ovf: got %b exp 1", overflow); end
    checks++; if (word_count !== 6'd32) begin errs++; $display("FAIL full_wc: got %0d exp 32", word_count); end
    load_en = 1'b0; step();
    checks++; if (load_done !== 1'b1) begin errs++; $display("FAIL full_done: got %b exp 1", load_done); end
    checks++; if (partial_err !== 1'b0) begin errs++; $display("FAIL full_perr: got %b exp 0", partial_err); end
    step();
    checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL full_ovf_sticky: got %b exp 1", overflow); end
  endtask

  task automatic test_partial();
    load_en = 1'b1; step();
    checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL partial_ovf_clear: got %b exp 0", overflow); end
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i + 1); step();
      if (i == 3) begin
        checks++; if (imem_we !== 1'b1 || imem_addr !== 5'd0 || imem_wdata !== 32'h04030201) begin errs++; $display("FAIL partial_write: got we=%b addr=%0d wdata=%h exp 1/0/04030201", imem_we, imem_addr, imem_wdata); end
      end
      if (i == 5) begin
        checks++; if (imem_we !== 1'b0) begin errs++; $display("FAIL partial_extra_we: got %b exp 0", imem_we); end
      end
    end
    rx_valid = 1'b0; load_en = 1'b0; step();
    checks++; if (partial_err !== 1'b1) begin errs++; $display("FAIL partial_perr: got %b exp 1", partial_err); end
    checks++; if (load_done !== 1'b1) begin errs++; $display("FAIL partial_done: got %b exp 1", load_done); end
    checks++; if (word_count !== 6'd1) begin errs++; $display("FAIL partial_wc: got %0d exp 1", word_count); end
    checks++; if (imem_we !== 1'b0) begin errs++; $display("FAIL partial_discard: got %b exp 0", imem_we); end
    step();
    checks++; if (partial_err !== 1'b1) begin errs++; $display("FAIL partial_sticky: got %b exp 1", partial_err); end
  endtask

  task automatic test_run();
    run_req = 1'b1; step();
    checks++; if (cpu_reset !== 1'b1 || cpu_start !== 1'b0) begin errs++; $display("FAIL run_entry: got rst=%b start=%b exp 1/0", cpu_reset, cpu_start); end
    checks++; if (rx_ready !== 1'b0) begin errs++; $display("FAIL run_ready: got %b exp 0", rx_ready); end
    step();
    checks++; if (cpu_reset !== 1'b0 || cpu_start !== 1'b1) begin errs++; $display("FAIL run_started: got rst=%b start=%b exp 0/1", cpu_reset, cpu_start); end
    step();
    checks++; if (cpu_start !== 1'b1 || imem_we !== 1'b0) begin errs++; $display("FAIL run_hold: got start=%b we=%b exp 1/0", cpu_start, imem_we); end
    run_req = 1'b0; step();
    checks++; if (cpu_start !== 1'b0 || cpu_reset !== 1'b0) begin errs++; $display("FAIL run_stop: got start=%b rst=%b exp 0/0", cpu_start, cpu_reset); end
    step();
    checks++; if (cpu_start !== 1'b0 || rx_ready !== 1'b0) begin errs++; $display("FAIL run_idle: got start=%b ready=%b exp 0/0", cpu_start, rx_ready); end
  endtask

  task automatic test_reload();
    logic [7:0] b [4];
    b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_req = 1'b1; step(); step();
    checks++; if (cpu_start !== 1'b1) begin errs++; $display("FAIL reload_running: got %b exp 1", cpu_start); end
    load_en = 1'b1; run_req = 1'b0; step();
    checks++; if (cpu_start !== 1'b0 || rx_ready !== 1'b1) begin errs++; $display("FAIL reload_switch: got start=%b ready=%b exp 0/1", cpu_start, rx_ready); end
    checks++; if (partial_err !== 1'b0 || overflow !== 1'b0 || word_count !== 6'd0) begin errs++; $display("FAIL reload_clear: got perr=%b ovf=%b wc=%0d exp 0/0/0", partial_err, overflow, word_count); end
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = b[i]; step();
    end
    rx_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 5'd0 || imem_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL reload_write: got we=%b addr=%0d wdata=%h exp 1/0/deadbeef", imem_we, imem_addr, imem_wdata); end
    load_en = 1'b0; step(); step();
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] b [4];
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_en = 1'b1; step();
    rx_valid = 1'b1; rx_data = 8'h11; step();
    rx_data = 8'h22; step();
    rx_valid = 1'b0; reset = 1'b1; step();
    checks++; if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_start, cpu_reset, word_count, load_done, overflow, partial_err} !== 50'd0) begin errs++; $display("FAIL midreset_outputs: got ready=%b wdata=%h wc=%0d", rx_ready, imem_wdata, word_count); end
    reset = 1'b0; step();
    checks++; if (rx_ready !== 1'b1) begin errs++; $display("FAIL midreset_reload: got %b exp 1", rx_ready); end
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = b[i]; step();
    end
    rx_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 5'd0 || imem_wdata !== 32'hDDCCBBAA) begin errs++; $display("FAIL midreset_write: got we=%b addr=%0d wdata=%h exp 1/0/ddccbbaa", imem_we, imem_addr, imem_wdata); end
  endtask

  task automatic test_gaps();
    logic [7:0] d [7];
    logic v [7];
    d = '{8'h01, 8'hFF, 8'hEE, 8'h02, 8'h77, 8'h03, 8'h55};
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      rx_valid = v[i]; rx_data = d[i]; step();
      checks++; if (imem_we !== 1'b0 || imem_addr !== 5'd0 || imem_wdata !== 32'hDDCCBBAA) begin errs++; $display("FAIL gaps_hold step %0d: got we=%b addr=%0d wdata=%h", i, imem_we, imem_addr, imem_wdata); end
    end
    rx_valid = 1'b1; rx_data = 8'h04; load_en = 1'b0; step();
    rx_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 5'd1 || imem_wdata !== 32'h04030201) begin errs++; $display("FAIL gaps_write: got we=%b addr=%0d wdata=%h exp 1/1/04030201", imem_we, imem_addr, imem_wdata); end
    checks++; if (load_done !== 1'b1 || partial_err !== 1'b0 || word_count !== 6'd2) begin errs++; $display("FAIL gaps_close: got done=%b perr=%b wc=%0d exp 1/0/2", load_done, partial_err, word_count); end
    step();
    checks++; if (imem_we !== 1'b0 || load_done !== 1'b0) begin errs++; $display("FAIL gaps_after: got we=%b done=%b exp 0/0", imem_we, load_done); end
  endtask

  task automatic test_priority();
    load_en = 1'b1; run_req = 1'b1; step();
    checks++; if (rx_ready !== 1'b1 || cpu_reset !== 1'b0) begin errs++; $display("FAIL priority: got ready=%b rst=%b exp 1/0", rx_ready, cpu_reset); end
    load_en = 1'b0; run_req = 1'b0; step(); step();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_memory();
    test_partial();
    test_run();
    test_reload();
    test_reset_mid_word();
    test_gaps();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
